// File: rtl/timer.sv
// Purpose : free-running divider producing a CPU-step strobe and a 60 Hz strobe.
// Latency : strobes decode the counters directly; one-cycle pulse once per period.
// Backpressure: none; the strobes are emitted unconditionally and cannot be stalled.
//
// Ports:
//   clk             system clock, all state updates on the rising edge
//   rst_n           asynchronous active-low reset, clears both counters
//   timer_cpu_tick  high for one cycle every CPU_DIV+1 cycles
//   timer_60hz_tick high for one cycle every HZ60_DIV+1 cycles
module timer #(
    parameter int CLOCK_SPEED = 100000,
    parameter int CPU_SPEED   = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic timer_cpu_tick,
    output logic timer_60hz_tick
);

    localparam int CPU_DIV  = CLOCK_SPEED / CPU_SPEED;
    localparam int HZ60_DIV = CLOCK_SPEED / 60;

    // A divisor of 0 would give a zero-width counter; keep at least one bit.
    // With a terminal count of 0 the counter simply stays at 0, so the tick
    // is permanently high.
    localparam int CPU_W = (CPU_DIV  < 1) ? 1 : $clog2(CPU_DIV + 1);
    localparam int HZ_W  = (HZ60_DIV < 1) ? 1 : $clog2(HZ60_DIV + 1);

    localparam logic [CPU_W-1:0] CPU_TC = CPU_W'(CPU_DIV);
    localparam logic [HZ_W-1:0]  HZ_TC  = HZ_W'(HZ60_DIV);

    logic [CPU_W-1:0] cpu_cnt;
    logic [HZ_W-1:0]  hz_cnt;

    // The counters are independent; both restart at 0 after reset, so the
    // ticks are high during reset and fire again exactly one period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_cnt <= '0;
        end else if (cpu_cnt == CPU_TC) begin
            cpu_cnt <= '0;
        end else begin
            cpu_cnt <= cpu_cnt + CPU_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz_cnt <= '0;
        end else if (hz_cnt == HZ_TC) begin
            hz_cnt <= '0;
        end else begin
            hz_cnt <= hz_cnt + HZ_W'(1);
        end
    end

    // Combinational decode: the strobe follows the counter (and async reset)
    // without an extra register stage.
    assign timer_cpu_tick  = (cpu_cnt == '0);
    assign timer_60hz_tick = (hz_cnt  == '0);

endmodule

// File: tb/tb_timer.sv
module tb_timer;

    localparam int BIG_CPU_P  = 100000 / 500 + 1;   // 201
    localparam int BIG_HZ_P   = 100000 / 60 + 1;    // 1667
    localparam int SML_CPU_P  = 1000 / 100 + 1;     // 11
    localparam int SML_HZ_P   = 1000 / 60 + 1;      // 17
    localparam int RUN_EDGES  = 10002;              // 6 full 60 Hz periods

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic big_cpu, big_hz, sml_cpu, sml_hz;

    timer u_big (
        .clk             (clk),
        .rst_n           (rst_n),
        .timer_cpu_tick  (big_cpu),
        .timer_60hz_tick (big_hz)
    );

    timer #(.CLOCK_SPEED(1000), .CPU_SPEED(100)) u_sml (
        .clk             (clk),
        .rst_n           (rst_n),
        .timer_cpu_tick  (sml_cpu),
        .timer_60hz_tick (sml_hz)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard: {big_cpu, big_hz, sml_cpu, sml_hz} expected after each edge.
    logic [3:0] exp_q[$];

    int edge_i;
    int cnt_big_cpu, cnt_big_hz, cnt_sml_cpu, cnt_sml_hz;
    logic prev_big_cpu, prev_big_hz, prev_sml_cpu, prev_sml_hz;

    task automatic chk(input string tag, input int edge_no, input logic obs, input logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, edge_no, obs, exp_v);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs == exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Model of the tick cadence: high after edge i iff i is a multiple of the period.
    function automatic logic [3:0] model(input int i);
        return {(i % BIG_CPU_P) == 0, (i % BIG_HZ_P) == 0,
                (i % SML_CPU_P) == 0, (i % SML_HZ_P) == 0};
    endfunction

    task automatic clear_stats();
        edge_i = 0;
        cnt_big_cpu = 0; cnt_big_hz = 0; cnt_sml_cpu = 0; cnt_sml_hz = 0;
        prev_big_cpu = 1'b1; prev_big_hz = 1'b1; prev_sml_cpu = 1'b1; prev_sml_hz = 1'b1;
    endtask

    // Advance n rising edges from the current phase, comparing every edge.
    task automatic run_edges(input int n);
        logic [3:0] e;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model(edge_i + 1));
            @(posedge clk);
            edge_i++;
            #1;
            e = exp_q.pop_front();
            chk("big_cpu", edge_i, big_cpu, e[3]);
            chk("big_hz",  edge_i, big_hz,  e[2]);
            chk("sml_cpu", edge_i, sml_cpu, e[1]);
            chk("sml_hz",  edge_i, sml_hz,  e[0]);
            // A tick must never stay high across two consecutive edges
            // (prev starts at 1 for the reset cycle, which is also covered).
            chk("big_cpu_b2b", edge_i, prev_big_cpu & big_cpu, 1'b0);
            chk("big_hz_b2b",  edge_i, prev_big_hz  & big_hz,  1'b0);
            chk("sml_cpu_b2b", edge_i, prev_sml_cpu & sml_cpu, 1'b0);
            chk("sml_hz_b2b",  edge_i, prev_sml_hz  & sml_hz,  1'b0);
            prev_big_cpu = big_cpu; prev_big_hz = big_hz;
            prev_sml_cpu = sml_cpu; prev_sml_hz = sml_hz;
            cnt_big_cpu += int'(big_cpu); cnt_big_hz += int'(big_hz);
            cnt_sml_cpu += int'(sml_cpu); cnt_sml_hz += int'(sml_hz);
        end
    endtask

    initial begin
        // Reset held: both ticks high with no clock edge yet.
        #2;
        chk("rst_t0_big_cpu", 0, big_cpu, 1'b1);
        chk("rst_t0_big_hz",  0, big_hz,  1'b1);
        chk("rst_t0_sml_cpu", 0, sml_cpu, 1'b1);
        chk("rst_t0_sml_hz",  0, sml_hz,  1'b1);

        // Edges during reset do not advance the counters.
        @(posedge clk); #1;
        chk("rst_edge_big_cpu", 0, big_cpu, 1'b1);
        chk("rst_edge_sml_hz",  0, sml_hz,  1'b1);

        // Release away from the edge and free-run.
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        run_edges(RUN_EDGES);
        chk_int("big_cpu_count", cnt_big_cpu, RUN_EDGES / BIG_CPU_P);
        chk_int("big_hz_count",  cnt_big_hz,  RUN_EDGES / BIG_HZ_P);
        chk_int("sml_cpu_count", cnt_sml_cpu, RUN_EDGES / SML_CPU_P);
        chk_int("sml_hz_count",  cnt_sml_hz,  RUN_EDGES / SML_HZ_P);

        // Restart cleanly, run to cycle 150, then reset between edges.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        clear_stats();
        run_edges(150);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_big_cpu", 150, big_cpu, 1'b1);
        chk("async_big_hz",  150, big_hz,  1'b1);
        chk("async_sml_cpu", 150, sml_cpu, 1'b1);
        chk("async_sml_hz",  150, sml_hz,  1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        // The per-edge model requires the next CPU tick exactly 201 edges on.
        run_edges(BIG_CPU_P + 1);
        chk_int("post_rst_cpu_count", cnt_big_cpu, 1);

        chk_int("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer.md
Name: timer

Overview:
- Free-running tick generator for the CHIP-8 core.
- Divides the single system clock into two periodic one-cycle strobes:
  - a CPU-step tick, which paces instruction execution;
  - a 60 Hz tick, which drives the delay/sound timer decrement.
- Both strobes are pure functions of internal counters; there are no inputs besides clock and reset.

Parameters:
- CLOCK_SPEED, 100000, system clock frequency in Hz.
- CPU_SPEED, 500, desired CPU instruction rate in Hz.
- CPU_DIV, CLOCK_SPEED/CPU_SPEED (integer division, 200 at defaults), terminal count of the CPU counter. Derived; not overridden.
- HZ60_DIV, CLOCK_SPEED/60 (integer division, 1666 at defaults), terminal count of the 60 Hz counter. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- timer_cpu_tick  output  1  CPU-step strobe; high for exactly one clk cycle per CPU period.
- timer_60hz_tick  output  1  60 Hz strobe; high for exactly one clk cycle per 60 Hz period.

Behaviour:
- Two independent counters:
  - cpu_cnt, width $clog2(CPU_DIV+1);
  - hz_cnt, width $clog2(HZ60_DIV+1).
- Reset: rst_n low asynchronously clears both counters to 0, independent of clk.
- Output values:
  - timer_cpu_tick = (cpu_cnt == 0), combinational decode, no extra register stage;
  - timer_60hz_tick = (hz_cnt == 0), same decode;
  - consequently both ticks read 1 during reset and at time zero after reset.
- Counting: on each rising clk edge with rst_n high:
  - cpu_cnt <= (cpu_cnt == CPU_DIV) ? 0 : cpu_cnt + 1;
  - hz_cnt <= (hz_cnt == HZ60_DIV) ? 0 : hz_cnt + 1.
- Periods:
  - CPU period = CPU_DIV+1 cycles (201 at defaults);
  - 60 Hz period = HZ60_DIV+1 cycles (1667 at defaults).
- Tick timing: numbering rising edges after reset release as i = 1, 2, …:
  - timer_cpu_tick is high after edge i iff i mod (CPU_DIV+1) == 0;
  - timer_60hz_tick is high after edge i iff i mod (HZ60_DIV+1) == 0.
- Tick width: each tick is high for exactly one cycle. Never high on two consecutive cycles, provided the divisor is ≥1.
- Simultaneous ticks: counters are fully independent. Both ticks are high on cycles that are common multiples of the two periods (cycle 0, then every lcm(201,1667) cycles at defaults). No priority or interaction between them.
- Wrap-around: the counters never exceed their terminal count. No overflow path exists, and no state other than 0 … DIV is reachable.
- Reset mid-operation: asserting rst_n at any cycle immediately forces both counters to 0 and both ticks to 1. Counting restarts from zero on the first rising edge after release.
- Degenerate divisors: a divisor of 0 (clock slower than the requested rate) makes the tick permanently high. This is legal.
- Integer division truncates. No rounding or fractional accumulation is required.

Test Plan:
- Reset/time zero: hold rst_n low, check both ticks = 1. Release, then check after the 1st edge that both ticks = 0.
- CPU cadence: free-run 400000 cycles. After each edge i, timer_cpu_tick == (i % 201 == 0). Check at least edges 200 (0), 201 (1), 202 (0), 402 (1).
- 60 Hz cadence: same run. timer_60hz_tick == (i % 1667 == 0). Check edges 1666 (0), 1667 (1), 3334 (1).
- Pulse width: over the full run, count cpu ticks = floor(400000/201) and 60 Hz ticks = floor(400000/1667). No back-to-back highs.
- Async reset mid-period: assert rst_n at cycle 150 between clock edges. Both ticks go to 1 without a clk edge. Release; the next cpu tick occurs exactly 201 edges later.
- Parameter override: CLOCK_SPEED=1000, CPU_SPEED=100. cpu tick every 11 cycles; 60 Hz tick every 17 cycles (1000/60 = 16, +1).
